decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised successor of the single-issue decode stage.
- Holds an NREG x XLEN register file with optional write-back bypass, decodes fields and immediates, and owns the ID/EX pipeline register.
- Detects load-use hazards against its own EX slot and inserts a programmable number of bubbles.
- Sits between the IF/ID register and the execute stage; stall_o feeds fetch and IF/ID.

Parameters:
- XLEN, 32, data path and immediate width (32 or 64).
- NREG, 32, architectural register count (16 = RV32E, or 32).
- BYPASS_EN, 1, 1 = same-cycle WB write is visible on the read ports.
- STALL_CYC, 1, bubbles inserted per load-use hazard (1..7).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  global enable; 0 freezes all state, including register-file writes.
- id_valid_i  in  1  id_instr_i holds a real instruction.
- id_instr_i  in  32  instruction from IF/ID.
- wb_we_i  in  1  write-back register write.
- wb_rd_i  in  5  write-back destination index.
- wb_data_i  in  XLEN  write-back data.
- flush_i  in  1  kill the ID instruction (taken branch or jump).
- stall_o  out  1  hold IF and IF/ID this cycle.
- ex_valid_o  out  1  EX slot holds a real instruction.
- ex_opcode_o  out  7  registered opcode.
- ex_alu_ctrl_o  out  4  registered {instr[30], instr[14:12]}.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered register indices.
- ex_rs1_data_o, ex_rs2_data_o  out  XLEN each  registered operands.
- ex_imm_o  out  XLEN  registered sign-extended immediate.
- ex_is_load_o  out  1  registered (opcode == 7'b0000011).

Behaviour:
- Reset (RST high, async): all ex_* = 0, stall_o = 0, FSM = IDLE, stall counter = 0, all registers = 0.
- Register file:
  - x0 reads 0 and ignores writes.
  - If NREG = 16, any index with bit 4 set reads 0 and its writes are dropped.
  - Write at posedge when EN & wb_we_i & (wb_rd_i != 0).
- Reads are combinational on rs1 = instr[19:15] and rs2 = instr[24:20]. rs1 is forced to 0 for LUI (opcode 0110111).
- Bypass:
  - BYPASS_EN = 1: if wb_we_i and wb_rd_i == rs and rs != 0, the read returns wb_data_i.
  - BYPASS_EN = 0: the read returns the stored value, and the new value is visible the next cycle.
- Immediate: RV32I I/S/B/U/J formats selected by opcode, sign-extended from instr[31] to XLEN. R-type and unknown opcodes give 0.
- Hazard condition `haz`: ex_valid_o & ex_is_load_o & (ex_rd_o != 0) & id_valid_i & (ex_rd_o == rs1 | ex_rd_o == rs2).
- FSM:
  - IDLE: if haz & !flush_i, go to STALL with cnt = STALL_CYC-1. stall_o = 1 combinationally in that same cycle.
  - STALL: stall_o = 1. cnt decrements each EN cycle. At cnt == 0 with EN, go to IDLE.
  - flush_i in STALL forces IDLE next cycle, and stall_o = 0 in that cycle.
- ID/EX register update at posedge, only when EN. Priority from highest:
  - 1. flush_i: bubble.
  - 2. stall_o: bubble.
  - 3. Otherwise, capture decoded fields; ex_valid_o = id_valid_i.
- Bubble means ex_valid_o = 0, ex_is_load_o = 0, ex_rd_o = 0. The other fields are don't-care but driven to 0.
- Latency: an instruction presented at cycle n appears on ex_* at cycle n+1.
- Under a hazard, the instruction reaches EX STALL_CYC cycles later. The upstream stage holds id_instr_i while stall_o = 1.
- EN = 0: the FSM, counter, ID/EX register and register file all hold. stall_o keeps its current value.
- Simultaneous WB write and EX capture of the same register: the bypass value is captured when BYPASS_EN = 1.
- RST asserted mid-stall: immediate return to IDLE, stall_o = 0, EX slot empty.

Test Plan:
- Write x5 = 0x0000_1234 via WB, then decode `addi x6,x5,-1` (0xFFF28313) → next cycle: ex_rs1_data_o = 0x1234, ex_imm_o = 0xFFFF_FFFF, ex_rd_o = 6, ex_valid_o = 1.
- Same-cycle WB x7 = 0xA5A5_A5A5 while decoding `add x8,x7,x0`:
  - BYPASS_EN = 1 → ex_rs1_data_o = 0xA5A5_A5A5.
  - BYPASS_EN = 0 → ex_rs1_data_o = old x7 (0 after reset).
- `lw x3,0(x1)` followed by `add x4,x3,x2` with STALL_CYC = 2:
  - stall_o high for exactly 2 cycles, with 2 bubbles (ex_valid_o = 0).
  - The add then appears in EX with ex_rs1_o = 3.
- Load-use hazard with flush_i asserted in the first stall cycle → stall_o = 0 that cycle, next EX slot is a bubble, FSM returns to IDLE.
- WB write to x0 with 0xFFFF_FFFF, then `add x1,x0,x0` → ex_rs1_data_o = ex_rs2_data_o = 0.
- NREG = 16: write x20 = 5 → read x20 = 0.
- RST pulsed mid-stall, asynchronously between clock edges → all ex_* = 0 and stall_o = 0 before the next edge.
- EN = 0 for 3 cycles during STALL → counter and outputs frozen; stall resumes when EN returns to 1.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with optional WB bypass, field/immediate decode,
// load-use hazard bubbling and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int BYPASS_EN = 1,
    parameter int STALL_CYC = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            id_valid_i,
    input  logic [31:0]     id_instr_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [6:0]      ex_opcode_o,
    output logic [3:0]      ex_alu_ctrl_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic            ex_is_load_o
);
    localparam int AW = $clog2(NREG);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [2:0] CNT_INIT  = 3'(STALL_CYC - 1);

    typedef enum logic {S_IDLE, S_STALL} state_t;

    // x0 and indices beyond the implemented file are hard-wired to zero
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREG);
    endfunction

    logic [XLEN-1:0]   rf_q [NREG];
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm;
    logic signed [31:0] imm32;
    logic              haz;

    assign opcode = id_instr_i[6:0];
    assign rs1    = (opcode == OP_LUI) ? 5'd0 : id_instr_i[19:15];
    assign rs2    = id_instr_i[24:20];

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (idx_ok(rs1)) begin
            rs1_data = rf_q[rs1[AW-1:0]];
            if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs1)) rs1_data = wb_data_i;
        end
        if (idx_ok(rs2)) begin
            rs2_data = rf_q[rs2[AW-1:0]];
            if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs2)) rs2_data = wb_data_i;
        end
    end

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
            OP_STORE:
                imm32 = {{20{id_instr_i[31]}}, id_instr_i[31:25], id_instr_i[11:7]};
            OP_BRANCH:
                imm32 = {{19{id_instr_i[31]}}, id_instr_i[31], id_instr_i[7],
                         id_instr_i[30:25], id_instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {id_instr_i[31:12], 12'b0};
            OP_JAL:
                imm32 = {{12{id_instr_i[31]}}, id_instr_i[19:12], id_instr_i[20],
                         id_instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

    assign haz = ex_valid_o && ex_is_load_o && (ex_rd_o != 5'd0) && id_valid_i &&
                 ((ex_rd_o == rs1) || (ex_rd_o == rs2));

    // The detecting IDLE cycle is itself the first bubble, so STALL covers the rest
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (haz && !flush_i) begin
                    stall_o = 1'b1;
                    if (STALL_CYC > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_STALL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else if (EN) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (EN && wb_we_i && idx_ok(wb_rd_i)) begin
            rf_q[wb_rd_i[AW-1:0]] <= wb_data_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid_o    <= 1'b0;
            ex_opcode_o   <= '0;
            ex_alu_ctrl_o <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_is_load_o  <= 1'b0;
        end else if (EN) begin
            if (flush_i || stall_o) begin
                ex_valid_o    <= 1'b0;
                ex_opcode_o   <= '0;
                ex_alu_ctrl_o <= '0;
                ex_rs1_o      <= '0;
                ex_rs2_o      <= '0;
                ex_rd_o       <= '0;
                ex_rs1_data_o <= '0;
                ex_rs2_data_o <= '0;
                ex_imm_o      <= '0;
                ex_is_load_o  <= 1'b0;
            end else begin
                ex_valid_o    <= id_valid_i;
                ex_opcode_o   <= opcode;
                ex_alu_ctrl_o <= {id_instr_i[30], id_instr_i[14:12]};
                ex_rs1_o      <= rs1;
                ex_rs2_o      <= rs2;
                ex_rd_o       <= id_instr_i[11:7];
                ex_rs1_data_o <= rs1_data;
                ex_rs2_data_o <= rs2_data;
                ex_imm_o      <= imm;
                ex_is_load_o  <= (opcode == OP_LOAD);
            end
        end
    end

endmodule
